dvp_rgb565_capture: RTL and testbench
=====================================

DVP_RGB565_CAPTURE -- requirements
Module: dvp_rgb565_capture

Interface
REQ-001 SHALL have parameter SKIP_FRAMES, default 10, the number of vsync rising edges discarded after reset while the sensor settles.
REQ-002 SHALL have parameter H_ACTIVE, default 480, the expected 16-bit words per line.
REQ-003 SHALL have parameter V_ACTIVE, default 272, the expected lines per frame.
REQ-004 SHALL have port clk  input  1  camera pixel clock (sensor PCLK); the only clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cmos_vsync  input  1  sensor vsync, active-high during vertical blanking.
REQ-007 SHALL have port cmos_href  input  1  sensor href, high while line bytes are valid.
REQ-008 SHALL have port cmos_data  input  8  sensor byte bus.
REQ-009 SHALL have port data_out  output  16  RGB565 word, {first byte, second byte}.
REQ-010 SHALL have port data_en  output  1  one-cycle write strobe for data_out (drives the downstream FIFO WrEn).
REQ-011 SHALL have port frame_vs  output  1  delayed vsync aligned to data_out (drives the downstream FIFO reset / frame-start detect).
REQ-012 SHALL have port frame_valid  output  1  high once the skip period has ended.
REQ-013 SHALL have port line_pixels  output  12  word count of the last completed line.
REQ-014 SHALL have port frame_lines  output  12  line count of the last completed frame.
REQ-015 SHALL have port size_err  output  1  last completed frame did not match H_ACTIVE x V_ACTIVE.

Function
REQ-016 SHALL register cmos_vsync, cmos_href and cmos_data into a sample stage on every rising clk edge; all logic works from the sample stage.
REQ-017 SHALL keep a byte phase bit: 0 while sampled href is low or sampled vsync is high; otherwise it toggles on every sampled byte.
REQ-018 Phase 0 byte SHALL be stored as the high byte; the phase 1 byte SHALL complete the word, with data_out = {high, low} and data_en = 1 for exactly one cycle, provided frame_valid = 1.
REQ-019 Latency SHALL be 2 clocks: a low byte present on cmos_data before edge k gives data_en high in the cycle after edge k+1.
REQ-020 frame_vs SHALL be cmos_vsync delayed by exactly 2 clocks, passed through regardless of frame_valid.
REQ-021 If href falls after an odd byte, the dangling high byte SHALL be discarded with no data_en, and the phase SHALL return to 0.
REQ-022 data_out SHALL hold its last value when data_en = 0.
REQ-023 A frame counter SHALL increment on each sampled vsync rising edge and saturate at SKIP_FRAMES; frame_valid = (count == SKIP_FRAMES); with SKIP_FRAMES = 0, frame_valid SHALL be 1 from the first cycle after reset release.
REQ-024 The pixel counter SHALL count emitted words in the current line, whether or not frame_valid is set; it SHALL saturate at 4095.
REQ-025 On a sampled href falling edge, line_pixels SHALL be set to the pixel count; the pixel counter SHALL clear; the line counter SHALL increment (saturate 4095); a line-mismatch flag SHALL be set if the count != H_ACTIVE.
REQ-026 On a sampled vsync rising edge, frame_lines SHALL be set to the line count; size_err SHALL be set to (line count != V_ACTIVE) OR the mismatch flag; the line count and mismatch flag SHALL clear.
REQ-027 A vsync rising edge mid-line (href still high) SHALL abort the line: the pixel counter clears, no line_pixels update, and the line is not counted.
REQ-028 If an href fall and a vsync rise are sampled in the same cycle, the line SHALL be counted first, then the frame SHALL be closed including that line.

Reset
REQ-029 While rst_n = 0, all outputs, the sample stage, counters, phase and flags SHALL be 0 (data_out = 16'h0000, frame_valid = 0 unless SKIP_FRAMES = 0 after release).
REQ-030 Asserting rst_n mid-line SHALL immediately clear state; after release, capture SHALL restart the skip count from 0.

Verification
REQ-031 SKIP_FRAMES=0, one line of bytes 0x12,0x34,0x56,0x78 -> data_en pulses twice, data_out 16'h1234 then 16'h5678, each 2 clocks after its low byte.
REQ-032 SKIP_FRAMES=2, three 4x2-word frames -> no data_en in frames 1-2; frame 3 produces 8 words; frame_valid rises on the 2nd vsync rise.
REQ-033 Line of 5 bytes -> 2 words emitted, 5th byte dropped, line_pixels = 2.
REQ-034 H_ACTIVE=4, V_ACTIVE=2, frame of 2 lines x 4 words -> size_err = 0, frame_lines = 2; next frame with 3 lines -> size_err = 1, frame_lines = 3.
REQ-035 vsync rises while href is high after 3 words -> pixel count clears, line_pixels unchanged, that line is excluded from frame_lines.
REQ-036 rst_n pulsed low mid-frame -> all outputs 0 asynchronously, frame_valid low until SKIP_FRAMES new vsync rises.

Source files
------------

// File: rtl/dvp_rgb565_capture.sv
// DVP camera capture: pairs sensor bytes into RGB565 words, gates output until the sensor settles, and measures line/frame geometry.
// Latency: two clocks from the low byte on cmos_data to data_en. No backpressure: the downstream FIFO must accept every data_en pulse.
module dvp_rgb565_capture #(
  parameter int SKIP_FRAMES = 10,
  parameter int H_ACTIVE    = 480,
  parameter int V_ACTIVE    = 272
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic [15:0] data_out,
  output logic        data_en,
  output logic        frame_vs,
  output logic        frame_valid,
  output logic [11:0] line_pixels,
  output logic [11:0] frame_lines,
  output logic        size_err
);

  localparam int          FCW     = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);
  localparam logic [FCW-1:0] SKIP_L = FCW'(SKIP_FRAMES);
  localparam logic [11:0] H_L     = 12'(H_ACTIVE);
  localparam logic [11:0] V_L     = 12'(V_ACTIVE);
  localparam logic [11:0] CNT_MAX = 12'hFFF;

  logic           vs_q, href_q, vs_prev_q, href_prev_q, vs_dly_q;
  logic [7:0]     dat_q;
  logic           phase_q, phase_d;
  logic [7:0]     hi_q, hi_d;
  logic [15:0]    data_out_q, data_out_d;
  logic           data_en_q, data_en_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           frame_valid_q, frame_valid_d;
  logic [11:0]    pix_cnt_q, pix_cnt_d;
  logic [11:0]    line_cnt_q, line_cnt_d;
  logic           line_bad_q, line_bad_d;
  logic           abort_q, abort_d;
  logic [11:0]    line_pixels_q, line_pixels_d;
  logic [11:0]    frame_lines_q, frame_lines_d;
  logic           size_err_q, size_err_d;

  logic           vs_rise, href_fall, byte_vld, word_done;
  logic           line_close, line_abort;
  logic [11:0]    line_cnt_upd;
  logic           line_bad_upd;

  always_comb begin
    vs_rise    = vs_q & ~vs_prev_q;
    href_fall  = ~href_q & href_prev_q;
    byte_vld   = href_q & ~vs_q;
    word_done  = byte_vld & phase_q;
    line_abort = vs_rise & href_q;
    // An aborted line still ends with an href fall later; it must not be counted.
    line_close = href_fall & ~abort_q;

    phase_d    = byte_vld ? ~phase_q : 1'b0;
    hi_d       = (byte_vld & ~phase_q) ? dat_q : hi_q;
    data_en_d  = word_done & frame_valid_q;
    data_out_d = data_en_d ? {hi_q, dat_q} : data_out_q;

    frame_cnt_d = frame_cnt_q;
    if (vs_rise && (frame_cnt_q != SKIP_L)) begin
      frame_cnt_d = frame_cnt_q + FCW'(1);
    end
    frame_valid_d = (frame_cnt_d == SKIP_L);

    pix_cnt_d = pix_cnt_q;
    if (href_fall || line_abort) begin
      pix_cnt_d = '0;
    end else if (word_done && (pix_cnt_q != CNT_MAX)) begin
      pix_cnt_d = pix_cnt_q + 12'd1;
    end

    if (line_abort) begin
      abort_d = 1'b1;
    end else if (!href_q) begin
      abort_d = 1'b0;
    end else begin
      abort_d = abort_q;
    end

    line_pixels_d = line_close ? pix_cnt_q : line_pixels_q;
    line_cnt_upd  = line_cnt_q;
    if (line_close && (line_cnt_q != CNT_MAX)) begin
      line_cnt_upd = line_cnt_q + 12'd1;
    end
    line_bad_upd = line_bad_q | (line_close & (pix_cnt_q != H_L));

    // A line closing in the same cycle as vsync rises belongs to the frame being closed.
    frame_lines_d = frame_lines_q;
    size_err_d    = size_err_q;
    line_cnt_d    = line_cnt_upd;
    line_bad_d    = line_bad_upd;
    if (vs_rise) begin
      frame_lines_d = line_cnt_upd;
      size_err_d    = (line_cnt_upd != V_L) | line_bad_upd;
      line_cnt_d    = '0;
      line_bad_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q          <= 1'b0;
      href_q        <= 1'b0;
      dat_q         <= '0;
      vs_prev_q     <= 1'b0;
      href_prev_q   <= 1'b0;
      vs_dly_q      <= 1'b0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      data_out_q    <= '0;
      data_en_q     <= 1'b0;
      frame_cnt_q   <= '0;
      frame_valid_q <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_bad_q    <= 1'b0;
      abort_q       <= 1'b0;
      line_pixels_q <= '0;
      frame_lines_q <= '0;
      size_err_q    <= 1'b0;
    end else begin
      vs_q          <= cmos_vsync;
      href_q        <= cmos_href;
      dat_q         <= cmos_data;
      vs_prev_q     <= vs_q;
      href_prev_q   <= href_q;
      vs_dly_q      <= vs_q;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      data_out_q    <= data_out_d;
      data_en_q     <= data_en_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_valid_q <= frame_valid_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_bad_q    <= line_bad_d;
      abort_q       <= abort_d;
      line_pixels_q <= line_pixels_d;
      frame_lines_q <= frame_lines_d;
      size_err_q    <= size_err_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_en     = data_en_q;
  assign frame_vs    = vs_dly_q;
  assign frame_valid = frame_valid_q;
  assign line_pixels = line_pixels_q;
  assign frame_lines = frame_lines_q;
  assign size_err    = size_err_q;

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Bench for dvp_rgb565_capture: two instances (skip 2 and skip 0) fed the same sensor stream, checked against a word/line/frame model.
module tb_dvp_rgb565_capture;
  localparam int HA   = 4;
  localparam int VA   = 2;
  localparam int LOGN = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_data = 8'h00;
  logic [15:0] a_out, z_out;
  logic        a_en, z_en, a_fvs, z_fvs, a_fv, z_fv, a_se, z_se;
  logic [11:0] a_lp, z_lp, a_fl, z_fl;

  dvp_rgb565_capture #(.SKIP_FRAMES(2), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
    .data_out(a_out), .data_en(a_en), .frame_vs(a_fvs), .frame_valid(a_fv),
    .line_pixels(a_lp), .frame_lines(a_fl), .size_err(a_se));

  dvp_rgb565_capture #(.SKIP_FRAMES(0), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
    .data_out(z_out), .data_en(z_en), .frame_vs(z_fvs), .frame_valid(z_fv),
    .line_pixels(z_lp), .frame_lines(z_fl), .size_err(z_se));

  always #5 clk = ~clk;

  int cyc = 0;
  bit vs_log  [LOGN];
  bit fvs_log [LOGN];
  bit rst_log [LOGN];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc + 1 < LOGN) vs_log[cyc+1] <= cmos_vsync;
  end

  logic [15:0] a_obs_w[$], z_obs_w[$], a_exp_w[$], z_exp_w[$];
  int          a_obs_c[$], z_obs_c[$], a_exp_c[$], z_exp_c[$];

  always @(negedge clk) begin
    if (a_en) begin a_obs_w.push_back(a_out); a_obs_c.push_back(cyc); end
    if (z_en) begin z_obs_w.push_back(z_out); z_obs_c.push_back(cyc); end
    if (cyc < LOGN) begin
      fvs_log[cyc] <= a_fvs;
      rst_log[cyc] <= rst_n;
    end
  end

  int errors = 0;
  int checks = 0;
  int vrises = 0, cur_lines = 0, cur_bad = 0, last_lp = 0, exp_fl = 0, exp_se = 0;
  logic [7:0] lb [64];

  // Inputs change on the falling edge; edge_no is the rising edge that samples them.
  task automatic drive(input logic vs, input logic hr, input logic [7:0] d, output int edge_no);
    @(negedge clk);
    cmos_vsync = vs;
    cmos_href  = hr;
    cmos_data  = d;
    edge_no    = cyc + 1;
  endtask

  task automatic idle(input int n, input logic vs);
    int e;
    repeat (n) drive(vs, 1'b0, 8'($urandom_range(0, 255)), e);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) lb[i] = 8'($urandom_range(0, 255));
  endtask

  // A word is due one edge after its low byte is sampled, if the skip period is over.
  task automatic feed_bytes(input int n);
    int e;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, lb[i], e);
      if (i % 2 == 1) begin
        z_exp_w.push_back({lb[i-1], lb[i]});
        z_exp_c.push_back(e + 1);
        if (vrises >= 2) begin
          a_exp_w.push_back({lb[i-1], lb[i]});
          a_exp_c.push_back(e + 1);
        end
      end
    end
  endtask

  task automatic close_line(input int n);
    last_lp = n / 2;
    cur_lines++;
    if (n / 2 != HA) cur_bad = 1;
  endtask

  task automatic close_frame();
    exp_fl    = cur_lines;
    exp_se    = ((cur_lines != VA) || (cur_bad != 0)) ? 1 : 0;
    cur_lines = 0;
    cur_bad   = 0;
    vrises++;
  endtask

  task automatic send_line(input int n, input bit end_vs);
    feed_bytes(n);
    close_line(n);
    if (end_vs) begin
      idle(3, 1'b1);
      idle(3, 1'b0);
      close_frame();
    end else begin
      idle(3, 1'b0);
    end
  endtask

  task automatic vsync_pulse();
    idle(3, 1'b1);
    idle(3, 1'b0);
    close_frame();
  endtask

  // Drains observed and expected words for one instance; n_bad counts value or timing differences.
  task automatic take_words(input bit z, output int n_obs, output int n_exp, output int n_bad,
                            output logic [15:0] fo, output logic [15:0] fe);
    logic [15:0] ow[$], ew[$];
    int oc[$], ec[$];
    if (z) begin
      ow = z_obs_w; oc = z_obs_c; ew = z_exp_w; ec = z_exp_c;
      z_obs_w.delete(); z_obs_c.delete(); z_exp_w.delete(); z_exp_c.delete();
    end else begin
      ow = a_obs_w; oc = a_obs_c; ew = a_exp_w; ec = a_exp_c;
      a_obs_w.delete(); a_obs_c.delete(); a_exp_w.delete(); a_exp_c.delete();
    end
    n_obs = ow.size();
    n_exp = ew.size();
    n_bad = 0;
    fo = '0;
    fe = '0;
    for (int i = 0; i < n_obs && i < n_exp; i++) begin
      if (ow[i] !== ew[i] || oc[i] != ec[i]) begin
        if (n_bad == 0) begin fo = ow[i]; fe = ew[i]; end
        n_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_out, a_en, a_fvs, a_fv, a_lp, a_fl, a_se} !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%h en=%b vs=%b fv=%b lp=%0d fl=%0d se=%b, want all zero",
               a_out, a_en, a_fvs, a_fv, a_lp, a_fl, a_se);
    end
    checks++;
    if (z_fv !== 1'b0) begin errors++; $display("FAIL reset_fv_skip0: got %b want 0", z_fv); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (z_fv !== 1'b1) begin errors++; $display("FAIL release_fv_skip0: got %b want 1", z_fv); end
    checks++;
    if (a_fv !== 1'b0) begin errors++; $display("FAIL release_fv_skip2: got %b want 0", a_fv); end
  endtask

  task automatic test_basic();
    int no, ne, nb;
    logic [15:0] fo, fe;
    lb[0] = 8'h12; lb[1] = 8'h34; lb[2] = 8'h56; lb[3] = 8'h78;
    send_line(4, 1'b0);
    take_words(1'b1, no, ne, nb, fo, fe);
    checks++;
    if (no !== 2) begin errors++; $display("FAIL basic_word_count: got %0d want 2", no); end
    checks++;
    if (nb !== 0) begin errors++; $display("FAIL basic_words: got %h want %h (%0d bad)", fo, fe, nb); end
    take_words(1'b0, no, ne, nb, fo, fe);
    checks++;
    if (no !== 0) begin errors++; $display("FAIL basic_skip_gated: got %0d words want 0", no); end
    checks++;
    if (a_lp !== 12'd2) begin errors++; $display("FAIL basic_line_pixels: got %0d want 2", a_lp); end
  endtask

  task automatic test_odd_line();
    int no, ne, nb;
    logic [15:0] fo, fe;
    fill_rand(5);
    send_line(5, 1'b0);
    take_words(1'b1, no, ne, nb, fo, fe);
    checks++;
    if (no !== 2) begin errors++; $display("FAIL odd_word_count: got %0d want 2", no); end
    checks++;
    if (nb !== 0) begin errors++; $display("FAIL odd_words: got %h want %h (%0d bad)", fo, fe, nb); end
    checks++;
    if (z_out !== {lb[2], lb[3]}) begin errors++; $display("FAIL odd_hold: got %h want %h", z_out, {lb[2], lb[3]}); end
    checks++;
    if (z_lp !== 12'(last_lp)) begin errors++; $display("FAIL odd_line_pixels: got %0d want %0d", z_lp, last_lp); end
  endtask

  task automatic test_skip_and_size();
    int no, ne, nb;
    logic [15:0] fo, fe;
    vsync_pulse();
    checks++;
    if (a_fl !== 12'(exp_fl) || a_se !== exp_se[0]) begin
      errors++; $display("FAIL frame1_size: got fl=%0d se=%b want fl=%0d se=%0d", a_fl, a_se, exp_fl, exp_se);
    end
    checks++;
    if (a_fv !== 1'b0) begin errors++; $display("FAIL fv_after_1st_rise: got %b want 0", a_fv); end
    for (int l = 0; l < 2; l++) begin fill_rand(8); send_line(8, 1'b0); end
    vsync_pulse();
    checks++;
    if (a_fl !== 12'd2 || a_se !== 1'b0) begin
      errors++; $display("FAIL frame2_size: got fl=%0d se=%b want fl=2 se=0", a_fl, a_se);
    end
    checks++;
    if (a_fv !== 1'b1) begin errors++; $display("FAIL fv_after_2nd_rise: got %b want 1", a_fv); end
    take_words(1'b0, no, ne, nb, fo, fe);
    checks++;
    if (no !== 0) begin errors++; $display("FAIL skipped_frames_words: got %0d want 0", no); end
    take_words(1'b1, no, ne, nb, fo, fe);
    checks++;
    if (no !== ne || nb !== 0) begin errors++; $display("FAIL skip0_words: got %0d words (%0d bad) want %0d", no, nb, ne); end
    for (int l = 0; l < 2; l++) begin fill_rand(8); send_line(8, 1'b0); end
    take_words(1'b0, no, ne, nb, fo, fe);
    checks++;
    if (no !== 8) begin errors++; $display("FAIL frame3_word_count: got %0d want 8", no); end
    checks++;
    if (nb !== 0) begin errors++; $display("FAIL frame3_words: got %h want %h (%0d bad)", fo, fe, nb); end
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin fill_rand(8); send_line(8, 1'b0); end
    vsync_pulse();
    checks++;
    if (a_fl !== 12'd3 || a_se !== 1'b1) begin
      errors++; $display("FAIL three_line_frame: got fl=%0d se=%b want fl=3 se=1", a_fl, a_se);
    end
    take_words(1'b0, no, ne, nb, fo, fe);
    checks++;
    if (no !== ne || nb !== 0) begin errors++; $display("FAIL frame4_words: got %0d words (%0d bad) want %0d", no, nb, ne); end
  endtask

  task automatic test_abort();
    int no, ne, nb, e;
    logic [15:0] fo, fe;
    fill_rand(10);
    send_line(10, 1'b0);
    checks++;
    if (a_lp !== 12'd5) begin errors++; $display("FAIL pre_abort_line_pixels: got %0d want 5", a_lp); end
    fill_rand(6);
    feed_bytes(6);
    repeat (2) drive(1'b1, 1'b1, 8'($urandom_range(0, 255)), e);
    idle(2, 1'b1);
    idle(3, 1'b0);
    close_frame();
    checks++;
    if (a_lp !== 12'd5) begin errors++; $display("FAIL abort_line_pixels: got %0d want 5", a_lp); end
    checks++;
    if (a_fl !== 12'(exp_fl) || a_se !== exp_se[0]) begin
      errors++; $display("FAIL abort_frame: got fl=%0d se=%b want fl=%0d se=%0d", a_fl, a_se, exp_fl, exp_se);
    end
    fill_rand(8);
    send_line(8, 1'b0);
    checks++;
    if (a_lp !== 12'd4) begin errors++; $display("FAIL post_abort_line_pixels: got %0d want 4", a_lp); end
    take_words(1'b0, no, ne, nb, fo, fe);
    checks++;
    if (no !== ne || nb !== 0) begin errors++; $display("FAIL abort_words: got %0d words (%0d bad) want %0d", no, nb, ne); end
  endtask

  task automatic test_simul();
    vsync_pulse();
    fill_rand(8);
    send_line(8, 1'b0);
    fill_rand(8);
    send_line(8, 1'b1);
    checks++;
    if (a_fl !== 12'd2 || a_se !== 1'b0) begin
      errors++; $display("FAIL fall_with_vsync_rise: got fl=%0d se=%b want fl=2 se=0", a_fl, a_se);
    end
  endtask

  task automatic test_random();
    int no, ne, nb, nl, n;
    logic [15:0] fo, fe;
    for (int f = 0; f < 4; f++) begin
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 2 * HA;
        fill_rand(n);
        send_line(n, (l == nl - 1) && ($urandom_range(0, 1) == 1));
        checks++;
        if (a_lp !== 12'(last_lp)) begin errors++; $display("FAIL rand_line_pixels: got %0d want %0d", a_lp, last_lp); end
      end
      if (cur_lines != 0) vsync_pulse();
      checks++;
      if (a_fl !== 12'(exp_fl) || a_se !== exp_se[0]) begin
        errors++; $display("FAIL rand_frame: got fl=%0d se=%b want fl=%0d se=%0d", a_fl, a_se, exp_fl, exp_se);
      end
    end
    take_words(1'b0, no, ne, nb, fo, fe);
    checks++;
    if (no !== ne || nb !== 0) begin errors++; $display("FAIL rand_words: got %0d words (%0d bad, %h vs %h) want %0d", no, nb, fo, fe, ne); end
    take_words(1'b1, no, ne, nb, fo, fe);
    checks++;
    if (no !== ne || nb !== 0) begin errors++; $display("FAIL rand_words_skip0: got %0d words (%0d bad) want %0d", no, nb, ne); end
  endtask

  task automatic test_reset_mid();
    int no, ne, nb, e;
    logic [15:0] fo, fe;
    fill_rand(4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, lb[i], e);
      if (i == 1) begin
        z_exp_w.push_back({lb[0], lb[1]}); z_exp_c.push_back(e + 1);
        a_exp_w.push_back({lb[0], lb[1]}); a_exp_c.push_back(e + 1);
      end
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_out, a_en, a_fvs, a_fv, a_lp, a_fl, a_se} !== 46'd0) begin
      errors++;
      $display("FAIL async_reset: got out=%h en=%b vs=%b fv=%b lp=%0d fl=%0d se=%b, want all zero",
               a_out, a_en, a_fvs, a_fv, a_lp, a_fl, a_se);
    end
    checks++;
    if ({z_out, z_en, z_fv, z_lp, z_fl} !== 42'd0) begin errors++; $display("FAIL async_reset_skip0: got out=%h fv=%b want zero", z_out, z_fv); end
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    vrises = 0; cur_lines = 0; cur_bad = 0; last_lp = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    take_words(1'b1, no, ne, nb, fo, fe);
    checks++;
    if (no !== 1 || nb !== 0) begin errors++; $display("FAIL reset_cut_word: got %0d words (%0d bad) want 1", no, nb); end
    take_words(1'b0, no, ne, nb, fo, fe);
    fill_rand(8);
    send_line(8, 1'b0);
    take_words(1'b0, no, ne, nb, fo, fe);
    checks++;
    if (no !== 0) begin errors++; $display("FAIL reskip_words: got %0d want 0", no); end
    vsync_pulse();
    checks++;
    if (a_fv !== 1'b0) begin errors++; $display("FAIL reskip_fv_1st: got %b want 0", a_fv); end
    vsync_pulse();
    checks++;
    if (a_fv !== 1'b1) begin errors++; $display("FAIL reskip_fv_2nd: got %b want 1", a_fv); end
    fill_rand(8);
    send_line(8, 1'b0);
    take_words(1'b0, no, ne, nb, fo, fe);
    checks++;
    if (no !== 4 || nb !== 0) begin errors++; $display("FAIL post_reset_words: got %0d words (%0d bad) want 4", no, nb); end
    take_words(1'b1, no, ne, nb, fo, fe);
  endtask

  // frame_vs after edge E must equal cmos_vsync sampled at edge E-1, outside reset.
  task automatic test_frame_vs();
    int bad, first, last_c;
    idle(2, 1'b0);
    bad = 0;
    first = -1;
    last_c = (cyc < LOGN) ? cyc - 1 : LOGN - 1;
    for (int c = 2; c <= last_c; c++) begin
      if (rst_log[c] && rst_log[c-1] && rst_log[c-2] && (fvs_log[c] !== vs_log[c-1])) begin
        if (first < 0) first = c;
        bad++;
      end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL frame_vs_delay: got %0d misaligned cycles (first at %0d) want 0", bad, first); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_line();
    test_skip_and_size();
    test_abort();
    test_simul();
    test_random();
    test_reset_mid();
    test_frame_vs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
